instruction_memory_responder: RTL and testbench

//  Responder side of the fetch interface: takes the PC's readAddress, returns the instruction word.

---
 rtl/instr_mem_pkg.sv | 5 +
 rtl/instr_mem_array.sv | 20 ++
 rtl/instruction_memory_responder.sv | 73 +++++++
 tb/tb_instruction_memory_responder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared NOP encoding and FSM state type for the instruction memory responder
package instr_mem_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    typedef enum logic {IMEM_LOAD, IMEM_RUN} imem_state_t;
endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: word storage with one write port and one enabled synchronous read port
module instr_mem_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/instruction_memory_responder.sv
// instruction_memory_responder: boot-loaded instruction store with 1-cycle fetch, stall and flush.
// Define MISALIGN_CHECK_EN to fault on fetches whose readAddress[1:0] is nonzero.
module instruction_memory_responder
    import instr_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] NOP_INSTR   = instr_mem_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] readAddress,
    input  logic        stall,
    input  logic        flush,
    input  logic        loadValid,
    input  logic [31:0] loadData,
    input  logic        loadDone,
    output logic        loadReady,
    output logic [31:0] instruction,
    output logic [31:0] instrAddress,
    output logic        instrValid,
    output logic        fault
);
    localparam int AW = $clog2(DEPTH_WORDS);

    imem_state_t state;
    logic [AW:0] load_ptr;
    logic [31:0] rdata;
    logic        in_range, fetch_ok, load_we, fetch_en;

    assign in_range = readAddress[31:AW+2] == '0;
`ifdef MISALIGN_CHECK_EN
    assign fetch_ok = in_range && readAddress[1:0] == 2'b00;
`else
    assign fetch_ok = in_range;
`endif
    // load_ptr's top bit marks the store as full (DEPTH_WORDS is a power of two)
    assign loadReady = state == IMEM_LOAD && !load_ptr[AW];
    assign load_we   = loadReady && loadValid;
    assign fetch_en  = state == IMEM_RUN && !flush && !stall && fetch_ok;
    // rdata only advances on a real fetch, so gating by instrValid yields NOP on flush/fault/reset
    assign instruction = instrValid ? rdata : NOP_INSTR;

    instr_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clock (clock),
        .we    (load_we),
        .waddr (load_ptr[AW-1:0]),
        .wdata (loadData),
        .re    (fetch_en),
        .raddr (readAddress[AW+1:2]),
        .rdata (rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IMEM_LOAD;
            load_ptr     <= '0;
            instrAddress <= '0;
            instrValid   <= 1'b0;
            fault        <= 1'b0;
        end else if (state == IMEM_LOAD) begin
            if (load_we) load_ptr <= load_ptr + 1'b1;
            if (loadDone) state <= IMEM_RUN;
        end else if (flush) begin
            instrAddress <= readAddress;
            instrValid   <= 1'b0;
            fault        <= 1'b0;
        end else if (!stall) begin
            instrAddress <= readAddress;
            instrValid   <= fetch_ok;
            fault        <= !fetch_ok;
        end
    end
endmodule

// File: tb/tb_instruction_memory_responder.sv
// tb_instruction_memory_responder: directed + randomized checks against a behavioural fetch/load model
module tb_instruction_memory_responder;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] readAddress = '0;
    logic        stall = 1'b0, flush = 1'b0, loadValid = 1'b0, loadDone = 1'b0;
    logic [31:0] loadData = '0;
    logic        loadReady, instrValid, fault;
    logic [31:0] instruction, instrAddress;

    always #5 clock = ~clock;

    instruction_memory_responder dut (
        .clock        (clock),
        .reset        (reset),
        .readAddress  (readAddress),
        .stall        (stall),
        .flush        (flush),
        .loadValid    (loadValid),
        .loadData     (loadData),
        .loadDone     (loadDone),
        .loadReady    (loadReady),
        .instruction  (instruction),
        .instrAddress (instrAddress),
        .instrValid   (instrValid),
        .fault        (fault)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_mem [DEPTH];
    int          mdl_ptr;
    bit          mdl_run;
    logic [31:0] e_instr, e_addr;
    logic        e_valid, e_fault;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".instruction"}, instruction, e_instr);
        chk({tag, ".instrAddress"}, instrAddress, e_addr);
        chk({tag, ".instrValid"}, {31'b0, instrValid}, {31'b0, e_valid});
        chk({tag, ".fault"}, {31'b0, fault}, {31'b0, e_fault});
        chk({tag, ".loadReady"}, {31'b0, loadReady}, {31'b0, !mdl_run && mdl_ptr < DEPTH});
    endtask

    task automatic mdl_reset();
        mdl_ptr = 0;
        mdl_run = 0;
        e_instr = NOP;
        e_addr  = '0;
        e_valid = 0;
        e_fault = 0;
    endtask

    // Drive one clock's worth of inputs, advance the model by the same edge, then compare
    task automatic cycle(string tag, bit lv, logic [31:0] ld, bit done, logic [31:0] addr, bit st, bit fl);
        bit ok;
        loadValid = lv; loadData = ld; loadDone = done; readAddress = addr; stall = st; flush = fl;
        if (!mdl_run) begin
            if (lv && mdl_ptr < DEPTH) begin
                mdl_mem[mdl_ptr] = ld;
                mdl_ptr++;
            end
            if (done) mdl_run = 1;
        end else if (fl) begin
            e_instr = NOP; e_valid = 0; e_fault = 0; e_addr = addr;
        end else if (!st) begin
            ok = (addr >> 2) < DEPTH;
`ifdef MISALIGN_CHECK_EN
            ok = ok && (addr % 4 == 0);
`endif
            e_addr = addr; e_valid = ok; e_fault = !ok;
            e_instr = NOP;
            if (ok) e_instr = mdl_mem[addr >> 2];
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_reset(string tag);
        reset = 1'b1;
        mdl_reset();
        #1;
        check_all(tag);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return 32'($urandom_range(0, DEPTH - 1) * 4);
        if (r == 7) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        if (r == 8) return 32'(DEPTH * 4 + $urandom_range(0, 15) * 4);
        return $urandom;
    endfunction

    initial begin
        logic [31:0] w0;
        mdl_reset();
        #1;
        pulse_reset("por");
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_all("post_reset");

        // Full load plus two overflow beats that must be dropped
        for (int i = 0; i < DEPTH + 2; i++) cycle("load", 1'b1, $urandom, 1'b0, $urandom, 1'b0, 1'b0);
        w0 = mdl_mem[0];
        for (int i = 0; i < 3; i++) cycle("load_idle", 1'b0, $urandom, 1'b0, $urandom, 1'($urandom), 1'($urandom));
        cycle("load_done", 1'b0, '0, 1'b1, 32'h0, 1'b0, 1'b0);
        cycle("word0_kept", 1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("word0_not_overwritten", instruction, w0);
        cycle("last_word", 1'b0, '0, 1'b0, 32'h3FC, 1'b0, 1'b0);
        cycle("range_edge", 1'b0, '0, 1'b0, 32'h400, 1'b0, 1'b0);
        chk("range_edge_fault", {31'b0, fault}, 32'd1);
        cycle("far_addr", 1'b0, '0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cycle("refetch", 1'b0, '0, 1'b0, 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("stall_hold", 1'b0, '0, 1'b0, rand_addr(), 1'b1, 1'b0);
        chk("stall_frozen_addr", instrAddress, 32'h10);
        cycle("flush_and_stall", 1'b0, '0, 1'b0, 32'h20, 1'b1, 1'b1);
        chk("flush_nop", instruction, 32'h00000013);
        cycle("after_flush", 1'b0, '0, 1'b0, 32'h24, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++)
            cycle("random_run", 1'($urandom), $urandom, 1'($urandom), rand_addr(),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);

        // Reset mid-load restarts at word 0; words beyond the new load keep old contents
        pulse_reset("reset_a");
        for (int i = 0; i < 3; i++) cycle("partial_load", 1'b1, $urandom, 1'b0, '0, 1'b0, 1'b0);
        pulse_reset("reset_mid_load");
        for (int i = 0; i < 4; i++) cycle("reload", 1'b1, $urandom, i == 3, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("fetch_seq", 1'b0, '0, 1'b0, 32'(i * 4), 1'b0, 1'b0);
        cycle("misalign", 1'b0, '0, 1'b0, 32'h2, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++)
            cycle("random_run2", 1'b0, '0, 1'b0, rand_addr(), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
